// File: rtl/cache_rd_axi_responder.sv
// ============================================================================
//  Module      : cache_rd_axi_responder
//  Description : Turns one cache read request into an AXI4 AR burst and returns
//                the R beats on ret_valid/ret_last/ret_data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_rd_axi_responder #(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] AR_ID      = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rd_req,
    input  logic [2:0]  rd_type,
    input  logic [31:0] rd_addr,
    output logic        rd_rdy,
    output logic        ret_valid,
    output logic        ret_last,
    output logic [31:0] ret_data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int          c_CNT_W     = $clog2(LINE_WORDS) + 1;
    localparam int          c_LINE_BITS = $clog2(LINE_WORDS * 4);
    localparam logic [7:0]  c_LINE_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [31:0] c_LINE_MASK = ~((32'd1 << c_LINE_BITS) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_araddr;
    logic [7:0]           r_arlen;
    logic [2:0]           r_arsize;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ret_valid;
    logic                 r_ret_last;
    logic [31:0]          r_ret_data;

    logic                 w_accept;
    logic                 w_beat;
    logic                 w_last_beat;
    logic [31:0]          w_araddr_nxt;
    logic [7:0]           w_arlen_nxt;
    logic [2:0]           w_arsize_nxt;

    assign w_accept    = (r_state == S_IDLE) && rd_req;
    assign w_beat      = (r_state == S_R) && rvalid;
    // rlast is deliberately ignored: the beat counter alone ends the burst.
    assign w_last_beat = w_beat && ({{(8 - c_CNT_W){1'b0}}, r_cnt} == r_arlen);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (rd_req)      w_state_nxt = S_AR;
            S_AR:    if (arready)     w_state_nxt = S_R;
            S_R:     if (w_last_beat) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_araddr_nxt = {rd_addr[31:2], 2'b00};
        w_arlen_nxt  = 8'd0;
        w_arsize_nxt = 3'd2;
        case (rd_type)
            3'b000: begin
                w_araddr_nxt = rd_addr;
                w_arsize_nxt = 3'd0;
            end
            3'b001: begin
                w_araddr_nxt = {rd_addr[31:1], 1'b0};
                w_arsize_nxt = 3'd1;
            end
            3'b100: begin
                w_araddr_nxt = rd_addr & c_LINE_MASK;
                w_arlen_nxt  = c_LINE_LEN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_araddr    <= 32'd0;
            r_arlen     <= 8'd0;
            r_arsize    <= 3'd0;
            r_cnt       <= '0;
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            r_ret_data  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_araddr <= w_araddr_nxt;
                r_arlen  <= w_arlen_nxt;
                r_arsize <= w_arsize_nxt;
                r_cnt    <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_ret_valid <= w_beat;
            r_ret_last  <= w_last_beat;
            if (w_beat) begin
                r_ret_data <= rdata;
            end
        end
    end

    assign rd_rdy    = (r_state == S_IDLE);
    assign arvalid   = (r_state == S_AR);
    assign rready    = (r_state == S_R);
    assign arid      = AR_ID;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = r_arsize;
    assign ret_valid = r_ret_valid;
    assign ret_last  = r_ret_last;
    assign ret_data  = r_ret_data;

    logic w_unused;
    assign w_unused = rlast;

endmodule

`default_nettype wire

// File: tb/tb_cache_rd_axi_responder.sv
// ============================================================================
//  Module      : tb_cache_rd_axi_responder
//  Description : Directed, table-driven bench for cache_rd_axi_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_rd_axi_responder;

    logic        clk;
    logic        resetn;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    cache_rd_axi_responder #(
        .LINE_WORDS (4),
        .AR_ID      (4'd0)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       rd_type;
        logic [31:0]      rd_addr;
        logic [31:0]      exp_araddr;
        logic [7:0]       exp_arlen;
        logic [2:0]       exp_arsize;
        int               ar_delay;
        int               gap;
        int               rlast_at;
        logic [3:0][31:0] data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] t, input logic [31:0] a, input logic [31:0] ea,
                                input logic [7:0] el, input logic [2:0] es, input int ard,
                                input int gap, input int rl, input logic [3:0][31:0] d);
        vec_t v;
        v.rd_type    = t;
        v.rd_addr    = a;
        v.exp_araddr = ea;
        v.exp_arlen  = el;
        v.exp_arsize = es;
        v.ar_delay   = ard;
        v.gap        = gap;
        v.rlast_at   = rl;
        v.data       = d;
        return v;
    endfunction

    // Starts at a falling edge with the DUT idle; ends at the falling edge showing ret_last.
    task automatic do_read(input vec_t v);
        int nb;
        nb = int'(v.exp_arlen) + 1;
        chk("rd_rdy_idle", {31'd0, rd_rdy}, 32'd1);
        rd_req  = 1'b1;
        rd_type = v.rd_type;
        rd_addr = v.rd_addr;
        @(negedge clk);
        rd_req  = 1'b0;
        rd_addr = 32'hffff_ffff;
        chk("arvalid", {31'd0, arvalid}, 32'd1);
        chk("araddr", araddr, v.exp_araddr);
        chk("arlen", {24'd0, arlen}, {24'd0, v.exp_arlen});
        chk("arsize", {29'd0, arsize}, {29'd0, v.exp_arsize});
        chk("arid", {28'd0, arid}, 32'd0);
        chk("rd_rdy_ar", {31'd0, rd_rdy}, 32'd0);
        chk("ret_valid_clear", {31'd0, ret_valid}, 32'd0);
        for (int d = 0; d < v.ar_delay; d++) begin
            rd_req = ~rd_req;
            rvalid = 1'b1;
            rdata  = 32'hbad0_0000 | d;
            @(negedge clk);
            chk("arvalid_stall", {31'd0, arvalid}, 32'd1);
            chk("araddr_stable", araddr, v.exp_araddr);
            chk("rd_rdy_stall", {31'd0, rd_rdy}, 32'd0);
            chk("ret_valid_stall", {31'd0, ret_valid}, 32'd0);
        end
        rd_req  = 1'b0;
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'hbadb_ad00;
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b0;
        chk("arvalid_done", {31'd0, arvalid}, 32'd0);
        chk("rready", {31'd0, rready}, 32'd1);
        chk("ret_valid_ar_cycle", {31'd0, ret_valid}, 32'd0);
        for (int b = 0; b < nb; b++) begin
            for (int g = 0; g < v.gap; g++) begin
                @(negedge clk);
                chk("ret_valid_gap", {31'd0, ret_valid}, 32'd0);
                chk("rready_gap", {31'd0, rready}, 32'd1);
            end
            rvalid = 1'b1;
            rdata  = v.data[b];
            rlast  = (v.rlast_at < 0) ? (b == nb - 1) : (b == v.rlast_at);
            @(negedge clk);
            rvalid = 1'b0;
            rlast  = 1'b0;
            chk("ret_valid", {31'd0, ret_valid}, 32'd1);
            chk("ret_data", ret_data, v.data[b]);
            chk("ret_last", {31'd0, ret_last}, {31'd0, b == nb - 1});
            chk("rd_rdy_beat", {31'd0, rd_rdy}, {31'd0, b == nb - 1});
            chk("arvalid_r", {31'd0, arvalid}, 32'd0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = mk(3'b010, 32'h1fc0_0104, 32'h1fc0_0104, 8'd0, 3'd2, 0, 2, -1,
                     {32'h0, 32'h0, 32'h0, 32'hdead_beef});
        vecs[1] = mk(3'b100, 32'h0000_1238, 32'h0000_1230, 8'd3, 3'd2, 0, 1, -1,
                     {32'h44, 32'h33, 32'h22, 32'h11});
        vecs[2] = mk(3'b000, 32'h1faf_f003, 32'h1faf_f003, 8'd0, 3'd0, 0, 0, -1,
                     {32'h0, 32'h0, 32'h0, 32'h0000_00a5});
        vecs[3] = mk(3'b001, 32'h1faf_f003, 32'h1faf_f002, 8'd0, 3'd1, 0, 0, -1,
                     {32'h0, 32'h0, 32'h0, 32'h0000_beef});
        vecs[4] = mk(3'b010, 32'h8000_0013, 32'h8000_0010, 8'd0, 3'd2, 5, 0, -1,
                     {32'h0, 32'h0, 32'h0, 32'h1234_5678});
        vecs[5] = mk(3'b100, 32'h0000_103c, 32'h0000_1030, 8'd3, 3'd2, 0, 0, -1,
                     {32'hd, 32'hc, 32'hb, 32'ha});
        vecs[6] = mk(3'b100, 32'h2000_0004, 32'h2000_0000, 8'd3, 3'd2, 1, 0, 1,
                     {32'h4444, 32'h3333, 32'h2222, 32'h1111});
        vecs[7] = mk(3'b111, 32'h1234_5677, 32'h1234_5674, 8'd0, 3'd2, 0, 1, -1,
                     {32'h0, 32'h0, 32'h0, 32'hcafe_f00d});

        resetn  = 1'b0;
        rd_req  = 1'b0;
        rd_type = 3'b000;
        rd_addr = 32'd0;
        arready = 1'b0;
        rdata   = 32'd0;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        #2;
        chk("rst_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_ret_valid", {31'd0, ret_valid}, 32'd0);
        chk("rst_ret_data", ret_data, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Each read starts in the IDLE cycle that carries the previous read's ret_last.
        for (int i = 0; i < 8; i++) begin
            do_read(vecs[i]);
        end

        // Reset in the middle of a line burst.
        rd_req  = 1'b1;
        rd_type = 3'b100;
        rd_addr = 32'h4000_0008;
        @(negedge clk);
        rd_req  = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rvalid = 1'b1;
            rdata  = 32'h5550 + b;
            @(negedge clk);
            chk("pre_rst_ret_valid", {31'd0, ret_valid}, 32'd1);
            chk("pre_rst_ret_data", ret_data, 32'h5550 + b);
        end
        rdata  = 32'h5552;
        resetn = 1'b0;
        #1;
        chk("mid_rst_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        chk("mid_rst_rready", {31'd0, rready}, 32'd0);
        chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("mid_rst_ret_valid", {31'd0, ret_valid}, 32'd0);
        chk("mid_rst_ret_last", {31'd0, ret_last}, 32'd0);
        chk("mid_rst_ret_data", ret_data, 32'd0);
        chk("mid_rst_araddr", araddr, 32'd0);
        chk("mid_rst_arlen", {24'd0, arlen}, 32'd0);
        chk("mid_rst_arsize", {29'd0, arsize}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_ret_valid", {31'd0, ret_valid}, 32'd0);
            chk("post_rst_rready", {31'd0, rready}, 32'd0);
        end
        rvalid = 1'b0;
        do_read(mk(3'b010, 32'h1fc0_0200, 32'h1fc0_0200, 8'd0, 3'd2, 1, 1, -1,
                   {32'h0, 32'h0, 32'h0, 32'h600d_f00d}));
        @(negedge clk);
        chk("final_ret_valid_clear", {31'd0, ret_valid}, 32'd0);
        chk("final_ret_last_clear", {31'd0, ret_last}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
